// File: rtl/nfu_2_ctrl_if.sv
// Handshake and data bundle between the NFU-2 controller and its neighbours
// (NFU-1 product stream, NFU-2 adder tree, NFU-3 consumer, layer control).
interface nfu_2_ctrl_if #(
  parameter int BIT_WIDTH = 16,
  parameter int Tn        = 16,
  parameter int CNT_WIDTH = 16
);
  logic                    i_start;
  logic [CNT_WIDTH-1:0]    i_num_iter;
  logic [CNT_WIDTH-1:0]    i_num_tiles;
  logic                    i_nfu1_valid;
  logic                    o_nfu1_ready;
  logic [BIT_WIDTH*Tn-1:0] i_nfu2_result;
  logic [BIT_WIDTH*Tn-1:0] o_psum;
  logic                    o_nfu3_valid;
  logic                    i_nfu3_ready;
  logic [BIT_WIDTH*Tn-1:0] o_nfu3_data;
  logic                    o_busy;
  logic                    o_done;

  // Environment side: drives layer control, NFU-1 beats, tree result, NFU-3 ready.
  modport master (
    output i_start, i_num_iter, i_num_tiles, i_nfu1_valid, i_nfu2_result, i_nfu3_ready,
    input  o_nfu1_ready, o_psum, o_nfu3_valid, o_nfu3_data, o_busy, o_done
  );

  modport slave (
    input  i_start, i_num_iter, i_num_tiles, i_nfu1_valid, i_nfu2_result, i_nfu3_ready,
    output o_nfu1_ready, o_psum, o_nfu3_valid, o_nfu3_data, o_busy, o_done
  );
endinterface

// File: rtl/nfu_2_ctrl.sv
// NFU-2 controller: sequences Ni/Tn input blocks per output tile, feeds the
// partial sum back into the adder tree and buffers finished tiles for NFU-3.
module nfu_2_ctrl #(
  parameter int BIT_WIDTH  = 16,
  parameter int Tn         = 16,
  parameter int PIPE_DEPTH = 1,
  parameter int CNT_WIDTH  = 16
) (
  input logic          clk,
  input logic          rst_n,
  nfu_2_ctrl_if.slave  bus
);
  localparam int W  = BIT_WIDTH * Tn;
  localparam int LW = $clog2(PIPE_DEPTH + 4);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] num_iter_q, num_tiles_q, iter_cnt_q, tile_cnt_q;
  logic                 done_q;

  // Tree pipe tracking: index 0 is the newest beat, PIPE_DEPTH-1 the tail.
  logic [PIPE_DEPTH-1:0] pv_q, pf_q, pl_q;
  logic [W-1:0]          acc_q;

  logic [W-1:0] fifo_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   occ_q;

  logic          beat_first, beat_last, final_beat;
  logic          tail_v, tail_first, tail_last;
  logic          push, pop, fits, ready, accept;
  logic [LW-1:0] inflight_last;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    inflight_last = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      inflight_last = inflight_last + LW'(pv_q[i] & pl_q[i]);
    end
  end

  assign beat_first = (iter_cnt_q == '0);
  assign beat_last  = (iter_cnt_q == num_iter_q - CNT_ONE);
  assign final_beat = beat_last && (tile_cnt_q == num_tiles_q - CNT_ONE);

  assign tail_v     = pv_q[PIPE_DEPTH-1];
  assign tail_first = tail_v && pf_q[PIPE_DEPTH-1];
  assign tail_last  = tail_v && pl_q[PIPE_DEPTH-1];

  assign push = tail_last;
  assign pop  = (occ_q != 2'd0) && bus.i_nfu3_ready;

  // The tree cannot stall, so a tile-closing beat needs a FIFO slot reserved
  // against everything already heading for the buffer.
  assign fits   = (LW'(occ_q) + inflight_last) < (LW'(2) + LW'(pop));
  assign ready  = (state_q == RUN) && (!beat_last || fits);
  assign accept = ready && bus.i_nfu1_valid;

  assign bus.o_nfu1_ready = ready;
  assign bus.o_psum       = tail_first ? '0 : acc_q;
  assign bus.o_nfu3_valid = (occ_q != 2'd0);
  assign bus.o_nfu3_data  = (occ_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_done       = done_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_iter_q  <= '0;
      num_tiles_q <= '0;
      iter_cnt_q  <= '0;
      tile_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            num_iter_q  <= bus.i_num_iter;
            num_tiles_q <= bus.i_num_tiles;
            iter_cnt_q  <= '0;
            tile_cnt_q  <= '0;
            state_q     <= (bus.i_num_iter == '0 || bus.i_num_tiles == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (beat_last) begin
              iter_cnt_q <= '0;
              tile_cnt_q <= tile_cnt_q + CNT_ONE;
            end else begin
              iter_cnt_q <= iter_cnt_q + CNT_ONE;
            end
            if (final_beat) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pv_q == '0 && occ_q == 2'd0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q  <= '0;
      pf_q  <= '0;
      pl_q  <= '0;
      acc_q <= '0;
    end else begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
        pv_q[i] <= pv_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
      pv_q[0] <= accept;
      pf_q[0] <= beat_first;
      pl_q[0] <= beat_last;
      if (tail_v) acc_q <= bus.i_nfu2_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty flag masks stale entries from the output.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.i_nfu2_result;
  end
endmodule

// File: tb/tb_nfu_2_ctrl.sv
// Randomised bench for nfu_2_ctrl: a behavioural adder tree plus a per-tile
// reference sum model drive the DUT and judge its partial sums and results.
module tb_nfu_2_ctrl;
  localparam int BW = 16;
  localparam int TN = 16;
  localparam int PD = 2;
  localparam int CW = 16;
  localparam int W  = BW * TN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nfu_2_ctrl_if #(.BIT_WIDTH(BW), .Tn(TN), .CNT_WIDTH(CW)) bus ();

  nfu_2_ctrl #(.BIT_WIDTH(BW), .Tn(TN), .PIPE_DEPTH(PD), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ladd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < TN; l++) r[l*BW +: BW] = a[l*BW +: BW] + b[l*BW +: BW];
    return r;
  endfunction

  // Reference state: beats accepted so far, running tile sum, expected results.
  logic [W-1:0] prod_drv;
  logic [W-1:0] ref_sum;
  logic [W-1:0] exp_q [$];
  int cur_iter, beat_n, acc_cnt, got_cnt, pushed_cnt, done_cnt;
  bit busy_seen;

  // Behavioural adder tree: PD-cycle latency, output = product + fed-back psum.
  logic         tv   [PD];
  logic [W-1:0] tp   [PD];
  logic [W-1:0] tpre [PD];
  logic         nv;
  logic [W-1:0] nprod, nprefix;

  assign bus.i_nfu2_result = tv[PD-1] ? ladd(tp[PD-1], bus.o_psum) : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PD; i++) begin
        tv[i]   <= 1'b0;
        tp[i]   <= '0;
        tpre[i] <= '0;
      end
    end else begin
      for (int i = PD - 1; i > 0; i--) begin
        tv[i]   <= tv[i-1];
        tp[i]   <= tp[i-1];
        tpre[i] <= tpre[i-1];
      end
      tv[0]   <= nv;
      tp[0]   <= nprod;
      tpre[0] <= nprefix;
    end
  end

  // Mid-cycle monitor: inputs are stable here, so this sees exactly what the next edge takes.
  always @(negedge clk) begin
    nv = 1'b0;
    if (rst_n) begin
      if (bus.i_nfu1_valid && bus.o_nfu1_ready && cur_iter > 0) begin
        if (beat_n % cur_iter == 0) ref_sum = '0;
        nprefix = ref_sum;
        nprod   = prod_drv;
        ref_sum = ladd(ref_sum, prod_drv);
        if (beat_n % cur_iter == cur_iter - 1) begin
          exp_q.push_back(ref_sum);
          pushed_cnt++;
        end
        beat_n++;
        acc_cnt++;
        nv = 1'b1;
      end
      if (bus.i_nfu1_valid && !bus.o_busy) check("ready_while_idle", W'(bus.o_nfu1_ready), '0);
      if (tv[PD-1]) check("psum_at_tail", bus.o_psum, tpre[PD-1]);
      if (bus.o_nfu3_valid && bus.i_nfu3_ready) begin
        got_cnt++;
        if (exp_q.size() == 0) check("pop_without_result", W'(got_cnt), W'(pushed_cnt));
        else check("tile_result", bus.o_nfu3_data, exp_q.pop_front());
      end
      if (bus.o_done) done_cnt++;
      if (bus.o_busy) busy_seen = 1'b1;
    end
  end

  task automatic clear_model();
    beat_n = 0; acc_cnt = 0; got_cnt = 0; pushed_cnt = 0; done_cnt = 0;
    busy_seen = 1'b0;
    ref_sum = '0;
    exp_q.delete();
  endtask

  task automatic rand_prod(input bit fixed);
    for (int l = 0; l < TN; l++) prod_drv[l*BW +: BW] = fixed ? BW'(1) : BW'($urandom);
  endtask

  task automatic do_start(input int niter, input int ntiles);
    @(posedge clk); #1;
    clear_model();
    cur_iter         = niter;
    bus.i_num_iter   = CW'(niter);
    bus.i_num_tiles  = CW'(ntiles);
    bus.i_nfu1_valid = 1'b0;
    bus.i_start      = 1'b1;
    @(posedge clk); #1;
    bus.i_start      = 1'b0;
  endtask

  task automatic cycle(input int vpct, input int rpct, input bit fixed, input bit noise,
                       input bit toggle, input int idx);
    @(posedge clk); #1;
    bus.i_nfu1_valid = toggle ? idx[0] == 1'b0 : ($urandom_range(99) < vpct);
    bus.i_nfu3_ready = ($urandom_range(99) < rpct);
    bus.i_start      = noise && bus.o_busy && ($urandom_range(5) == 0);
    rand_prod(fixed);
  endtask

  task automatic finish_checks(input int niter, input int ntiles);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      bus.i_nfu1_valid = 1'b1;
      bus.i_nfu3_ready = 1'b1;
      bus.i_start      = 1'b0;
    end
    check("done_pulses", W'(done_cnt), W'(1));
    check("beats_accepted", W'(acc_cnt), W'(niter * ntiles));
    check("results_delivered", W'(got_cnt), W'((niter == 0) ? 0 : ntiles));
    check("results_left", W'(exp_q.size()), '0);
    check("busy_after_done", W'(bus.o_busy), '0);
    bus.i_nfu1_valid = 1'b0;
  endtask

  task automatic drive_run(input int niter, input int ntiles, input int vpct, input int rpct,
                           input bit fixed, input bit noise, input bit toggle);
    do_start(niter, ntiles);
    for (int c = 0; c < 4000 && done_cnt == 0; c++) cycle(vpct, rpct, fixed, noise, toggle, c);
    finish_checks(niter, ntiles);
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_num_iter = '0; bus.i_num_tiles = '0;
    bus.i_nfu1_valid = 1'b0; bus.i_nfu3_ready = 1'b0;
    prod_drv = '0; nprod = '0; nprefix = '0; cur_iter = 0;
    clear_model();

    // Outputs under reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", W'(bus.o_nfu1_ready), '0);
    check("rst_nfu3_valid", W'(bus.o_nfu3_valid), '0);
    check("rst_busy", W'(bus.o_busy), '0);
    check("rst_done", W'(bus.o_done), '0);
    check("rst_psum", bus.o_psum, '0);
    check("rst_nfu3_data", bus.o_nfu3_data, '0);
    rst_n = 1'b1;

    // Single tile, results climb 1,2,3,4 in every lane.
    drive_run(4, 1, 100, 100, 1'b1, 1'b0, 1'b0);

    // Back-to-back one-beat tiles with NFU-3 stalled.
    do_start(1, 5);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      bus.i_nfu1_valid = 1'b1;
      bus.i_nfu3_ready = 1'b0;
      rand_prod(1'b0);
    end
    check("stalled_beats", W'(acc_cnt), W'(2));
    check("stalled_ready", W'(bus.o_nfu1_ready), '0);
    for (int c = 0; c < 400 && done_cnt == 0; c++) cycle(100, 100, 1'b0, 1'b0, 1'b0, c);
    finish_checks(1, 5);

    // Zero counts.
    drive_run(3, 0, 100, 100, 1'b0, 1'b0, 1'b0);
    check("zero_tiles_busy", W'(busy_seen), W'(1));
    drive_run(0, 2, 100, 100, 1'b0, 1'b0, 1'b0);
    check("zero_iter_busy", W'(busy_seen), W'(1));

    // Reset after two of four beats.
    do_start(4, 1);
    for (int c = 0; c < 50 && acc_cnt < 2; c++) cycle(100, 100, 1'b0, 1'b0, 1'b0, c);
    bus.i_nfu1_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", W'(bus.o_nfu1_ready), '0);
    check("midrst_nfu3_valid", W'(bus.o_nfu3_valid), '0);
    check("midrst_busy", W'(bus.o_busy), '0);
    check("midrst_done", W'(bus.o_done), '0);
    check("midrst_psum", bus.o_psum, '0);
    check("midrst_nfu3_data", bus.o_nfu3_data, '0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_run(4, 1, 100, 100, 1'b0, 1'b0, 1'b0);

    // Start pulses while busy, valid alternating.
    drive_run(3, 3, 0, 100, 1'b0, 1'b1, 1'b1);

    // Randomised layers with gaps, backpressure and stray starts.
    for (int r = 0; r < 14; r++) begin
      drive_run($urandom_range(1, 5), $urandom_range(1, 6), $urandom_range(40, 100),
                $urandom_range(20, 100), 1'b0, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule

// File: doc/nfu_2_ctrl.md
NFU_2_CTRL -- requirements
Module: nfu_2_ctrl

Interface
REQ-001 Parameters SHALL be:
- BIT_WIDTH, default 16, lane width.
- Tn, default 16, lanes per beat.
- PIPE_DEPTH, default 1, register stages in the NFU-2 tree before the partial-sum adder.
- CNT_WIDTH, default 16, width of the iteration and tile counters.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse, sampled only in IDLE.
- i_num_iter  in  CNT_WIDTH  input blocks per output tile (Ni/Tn).
- i_num_tiles  in  CNT_WIDTH  output tiles per layer (Nn/Tn).
- i_nfu1_valid  in  1  NFU-1 product beat available.
- o_nfu1_ready  out  1  beat accepted into NFU-2 this cycle when high with valid.
- i_nfu2_result  in  BIT_WIDTH*Tn  NFU-2 o_nfu2_out.
- o_psum  out  BIT_WIDTH*Tn  partial sum driven to NFU-2 i_nbout.
- o_nfu3_valid  out  1  output buffer head valid.
- i_nfu3_ready  in  1  NFU-3 accepts the head.
- o_nfu3_data  out  BIT_WIDTH*Tn  completed tile sum.
- o_busy  out  1  state is not IDLE.
- o_done  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-004 In IDLE, i_start SHALL latch i_num_iter and i_num_tiles, clear both counters and enter RUN; i_start SHALL be ignored outside IDLE.
REQ-005 If either latched count is 0, the FSM SHALL go IDLE->DRAIN, issue no beats and pulse o_done once the pipe and buffer are empty.
REQ-006 A beat SHALL be accepted when i_nfu1_valid && o_nfu1_ready; o_nfu1_ready SHALL be 0 outside RUN.
REQ-007 Each accepted beat SHALL enter a PIPE_DEPTH-deep shift register carrying {valid, first, last}.
- first: iter_cnt==0.
- last: iter_cnt==num_iter-1.
REQ-008 On acceptance, iter_cnt SHALL increment; at num_iter-1 it SHALL wrap to 0 and tile_cnt SHALL increment.
REQ-009 Acceptance of the final beat (last tile, last iteration) SHALL move the FSM RUN->DRAIN.
REQ-010 o_psum SHALL be 0 while the shift-register tail holds a first beat; otherwise it SHALL be the internal accumulator register.
REQ-011 When the tail holds a valid beat, the accumulator SHALL capture i_nfu2_result at the clock edge, giving back-to-back accumulation with no stall.
REQ-012 When the tail holds a last beat, i_nfu2_result SHALL be pushed into a 2-entry output FIFO; the accumulator value is don't-care afterwards.
REQ-013 o_nfu3_valid SHALL equal FIFO not-empty; o_nfu3_data SHALL be the FIFO head; the head SHALL pop when o_nfu3_valid && i_nfu3_ready.
REQ-014 Simultaneous push and pop SHALL be legal in any FIFO occupancy, including full-with-pop.
REQ-015 The tree pipe cannot stall, so a beat whose last flag is 1 SHALL be accepted only if (FIFO occupancy + in-flight last beats − pop this cycle) < 2; non-last beats SHALL never be blocked by the FIFO.
REQ-016 In DRAIN, when the shift register holds no valid beat and the FIFO is empty, the FSM SHALL pulse o_done for one cycle and return to IDLE.
REQ-017 Counters SHALL compare with CNT_WIDTH-bit unsigned arithmetic, and results SHALL pass unmodified (no saturation in this block).

Reset
REQ-018 While rst_n is 0, the FSM SHALL be IDLE, and counters, the shift register, the accumulator and FIFO pointers/occupancy SHALL be 0.
REQ-019 During and after reset, until the next start, these outputs SHALL read 0: o_nfu1_ready, o_nfu3_valid, o_busy, o_done, o_psum, o_nfu3_data.
REQ-020 Reset asserted mid-RUN SHALL discard all in-flight beats and buffered results without emitting them.

Verification
REQ-021 Single tile:
- Stimulus: num_iter=4, num_tiles=1, valid held high, results 1,2,3,4, i_nfu3_ready=1.
- Response: o_psum sequence 0,1,2,3 at the tail; one o_nfu3_valid with data 4; o_done 1 cycle after the FIFO empties.
REQ-022 Back-to-back tiles under backpressure:
- Stimulus: num_iter=1, num_tiles=5, i_nfu3_ready=0.
- Response: exactly 2 beats accepted, then o_nfu1_ready=0; releasing ready delivers 5 results in order with none lost.
REQ-023 Zero count:
- Stimulus: num_tiles=0, then i_start.
- Response: no ready asserted; o_busy high for ≥1 cycle; single o_done pulse.
REQ-024 Reset mid-operation:
- Stimulus: rst_n low after 2 of 4 beats of a tile.
- Response: all outputs 0 immediately; the next start produces a correct tile starting from o_psum=0.
REQ-025 Start while busy and valid gaps:
- Stimulus: i_start pulsed during RUN; valid toggling 1,0,1,0.
- Response: the start is ignored; counters advance only on accepted beats; the final sum matches the reference sum.
